huffman_decode: RTL and testbench

Bit-serial Huffman decoder, the receive side of the `HuffmanCode` encoder. It holds a 10-entry code table, written by the host or captured from the encoder's per-symbol `data_out`/`data_len` output. It consumes a code bitstream one bit per cycle, root-level bit first, and emits the symbol index each time the accumulated bits match a table entry of equal length. It sits between the bit-transport path and the symbol consumer.

---
 rtl/huffman_decode.sv | 179 +++++++++++++++++
 tb/tb_huffman_decode.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_decode.sv
// huffman_decode: bit-serial Huffman decoder with a host-loaded code table.
//
// The host loads up to NSYM codes in LOAD. dec_start moves to DECODE. Bits then
// arrive root-level first, and each one is shifted into an accumulator. A symbol
// index is emitted when the accumulated bits equal a table entry of the same
// length.
//
// Optional feature: define HUFF_DEC_ERR_EN to build the ERROR state. With it,
// a code that reaches CWIDTH bits without a match locks the decoder in ERROR.
// Without it, such a code is dropped silently, DECODE continues and err stays 0.
//
// state  | meaning
// -------+-------------------------------------------------------------
// LOAD   | table writable, bit input not ready
// DECODE | accepting bits, matching against the table
// ERROR  | overlong code seen; bits ignored until dec_clr (macro only)

module huffman_decode #(
    parameter int NSYM   = 10,
    parameter int CWIDTH = 9,
    parameter int LWIDTH = 4,
    parameter int IWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tbl_wr,
    input  logic [IWIDTH-1:0] tbl_idx,
    input  logic [CWIDTH-1:0] tbl_code,
    input  logic [LWIDTH-1:0] tbl_len,
    input  logic              dec_start,
    input  logic              dec_clr,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              bit_ready,
    output logic              sym_valid,
    output logic [IWIDTH-1:0] sym_out,
    output logic              err
);

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_DECODE = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CWIDTH-1:0] code_tbl [NSYM];
    logic [LWIDTH-1:0] len_tbl  [NSYM];

    // Only CWIDTH-1 bits are ever kept: a code that reaches CWIDTH bits either
    // matches or is dropped, so the accumulator never has to hold all CWIDTH.
    logic [CWIDTH-2:0] acc;
    logic [LWIDTH-1:0] cnt;

    logic [CWIDTH-1:0] acc_n;
    logic [LWIDTH-1:0] cnt_n;
    logic [CWIDTH-1:0] len_mask;
    logic              accept;
    logic              match;
    logic [IWIDTH-1:0] match_idx;
    logic              overlong;

    // Candidate accumulator and match search for the bit on the input this cycle
    always_comb begin
        accept    = bit_valid && (state == S_DECODE);
        acc_n     = {acc, bit_in};
        cnt_n     = cnt + 1'b1;
        len_mask  = ~({CWIDTH{1'b1}} << cnt_n);
        match     = 1'b0;
        match_idx = '0;
        // Walk downward so that the lowest matching index is the one kept.
        for (int i = NSYM - 1; i >= 0; i--) begin
            if ((len_tbl[i] == cnt_n) && (((acc_n ^ code_tbl[i]) & len_mask) == '0)) begin
                match     = 1'b1;
                match_idx = IWIDTH'(i);
            end
        end
        overlong = !match && (cnt_n == LWIDTH'(CWIDTH));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; dec_clr overrides everything else
    always_comb begin
        state_nxt = state;
        if (dec_clr) begin
            state_nxt = S_LOAD;
        end else begin
            case (state)
                S_LOAD: begin
                    if (dec_start) begin
                        state_nxt = S_DECODE;
                    end
                end
                S_DECODE: begin
`ifdef HUFF_DEC_ERR_EN
                    if (accept && overlong) begin
                        state_nxt = S_ERROR;
                    end
`endif
                end
`ifdef HUFF_DEC_ERR_EN
                S_ERROR: begin
                    state_nxt = S_ERROR;
                end
`endif
                default: begin
                    state_nxt = S_LOAD;
                end
            endcase
        end
    end

    // Output decode of the registered state
    always_comb begin
        bit_ready = (state == S_DECODE);
        err       = 1'b0;
`ifdef HUFF_DEC_ERR_EN
        err       = (state == S_ERROR);
`endif
    end

    // Code table: written only in LOAD; out-of-range indices fall through the loop
    always_ff @(posedge clk) begin
        if (!rst_n || dec_clr) begin
            for (int i = 0; i < NSYM; i++) begin
                code_tbl[i] <= '0;
                len_tbl[i]  <= '0;
            end
        end else if (state == S_LOAD && tbl_wr) begin
            for (int i = 0; i < NSYM; i++) begin
                if (tbl_idx == IWIDTH'(i)) begin
                    code_tbl[i] <= tbl_code;
                    len_tbl[i]  <= tbl_len;
                end
            end
        end
    end

    // Accumulator, bit count and symbol output register
    always_ff @(posedge clk) begin
        if (!rst_n || dec_clr) begin
            acc       <= '0;
            cnt       <= '0;
            sym_valid <= 1'b0;
            sym_out   <= '0;
        end else begin
            sym_valid <= 1'b0;
            if (state == S_LOAD && dec_start) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (match) begin
                    sym_out   <= match_idx;
                    sym_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else if (overlong) begin
                    // Dropped code; with the error build the state also moves to ERROR.
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= acc_n[CWIDTH-2:0];
                    cnt <= cnt_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_huffman_decode.sv
// Testbench for huffman_decode: table-driven code stream plus scoreboard of
// expected symbols and their cycle of arrival, and hand-written corner cases.
module tb_huffman_decode;

    localparam int NSYM   = 10;
    localparam int CWIDTH = 9;
    localparam int LWIDTH = 4;
    localparam int IWIDTH = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              tbl_wr;
    logic [IWIDTH-1:0] tbl_idx;
    logic [CWIDTH-1:0] tbl_code;
    logic [LWIDTH-1:0] tbl_len;
    logic              dec_start;
    logic              dec_clr;
    logic              bit_valid;
    logic              bit_in;
    logic              bit_ready;
    logic              sym_valid;
    logic [IWIDTH-1:0] sym_out;
    logic              err;

    huffman_decode #(
        .NSYM(NSYM), .CWIDTH(CWIDTH), .LWIDTH(LWIDTH), .IWIDTH(IWIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tbl_wr(tbl_wr), .tbl_idx(tbl_idx),
        .tbl_code(tbl_code), .tbl_len(tbl_len), .dec_start(dec_start),
        .dec_clr(dec_clr), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(bit_ready), .sym_valid(sym_valid), .sym_out(sym_out),
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IWIDTH-1:0] sym;
        int                cyc;
    } exp_t;

    typedef struct {
        logic [CWIDTH-1:0] code;
        int                len;
        bit                bubble;
        int                exp_sym;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    logic [CWIDTH-1:0] g_code [4] = '{9'd0, 9'd2, 9'd6, 9'd7};
    int                g_len  [4] = '{1, 2, 3, 3};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every sym_valid must match the oldest expected symbol and cycle
    always @(negedge clk) begin
        if (rst_n === 1'b1 && sym_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_sym: got sym_valid with sym_out %0d, want no symbol", sym_out);
            end else begin
                mon_e = sb.pop_front();
                chk("sym_out", 32'(sym_out), 32'(mon_e.sym));
                chk("sym_latency", cyc, mon_e.cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [CWIDTH-1:0] c, input int l);
        tbl_wr   = 1'b1;
        tbl_idx  = IWIDTH'(idx);
        tbl_code = c;
        tbl_len  = LWIDTH'(l);
        tick();
        tbl_wr   = 1'b0;
    endtask

    task automatic clr();
        dec_clr = 1'b1;
        tick();
        dec_clr = 1'b0;
    endtask

    task automatic start();
        dec_start = 1'b1;
        tick();
        dec_start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit is_last, input int sym);
        exp_t e;
        bit_valid = 1'b1;
        bit_in    = b;
        if (is_last) begin
            e.sym = IWIDTH'(sym);
            e.cyc = cyc + 1;
            sb.push_back(e);
        end
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic send_code(input logic [CWIDTH-1:0] c, input int l, input int sym, input bit bubble);
        for (int b = l - 1; b >= 0; b--) begin
            send_bit(c[b], b == 0, sym);
            if (bubble) tick();
        end
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        chk(name, sb.size(), 0);
        sb.delete();
    endtask

    task automatic load_basic();
        for (int i = 0; i < 4; i++) wr(i, g_code[i], g_len[i]);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{9'b0,   1, 1'b0, 0};
        vecs[1]  = '{9'b10,  2, 1'b0, 1};
        vecs[2]  = '{9'b110, 3, 1'b0, 2};
        vecs[3]  = '{9'b111, 3, 1'b0, 3};
        vecs[4]  = '{9'b0,   1, 1'b1, 0};
        vecs[5]  = '{9'b10,  2, 1'b1, 1};
        vecs[6]  = '{9'b110, 3, 1'b1, 2};
        vecs[7]  = '{9'b111, 3, 1'b1, 3};
        vecs[8]  = '{9'b0,   1, 1'b0, 0};
        vecs[9]  = '{9'b0,   1, 1'b0, 0};
        vecs[10] = '{9'b0,   1, 1'b0, 0};
        vecs[11] = '{9'b111, 3, 1'b1, 3};

        rst_n = 1'b0; tbl_wr = 1'b0; tbl_idx = '0; tbl_code = '0; tbl_len = '0;
        dec_start = 1'b0; dec_clr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        tick();
        tick();
        chk("rst_bit_ready", 32'(bit_ready), 0);
        chk("rst_sym_valid", 32'(sym_valid), 0);
        chk("rst_sym_out", 32'(sym_out), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        tick();

        // Basic table; the last write coincides with dec_start
        for (int i = 0; i < 3; i++) wr(i, g_code[i], g_len[i]);
        chk("load_bit_ready", 32'(bit_ready), 0);
        tbl_wr = 1'b1; tbl_idx = 4'd3; tbl_code = 9'b111; tbl_len = 4'd3; dec_start = 1'b1;
        tick();
        tbl_wr = 1'b0; dec_start = 1'b0;
        chk("start_bit_ready", 32'(bit_ready), 1);

        for (int i = 0; i < 12; i++) send_code(vecs[i].code, vecs[i].len, vecs[i].exp_sym, vecs[i].bubble);
        drain("vec_drained");

        for (int i = 0; i < 30; i++) begin
            int s;
            s = int'($urandom_range(0, 3));
            send_code(g_code[s], g_len[s], s, bit'($urandom_range(0, 1)));
        end
        drain("rand_drained");

        // Table write and dec_start while decoding are ignored
        dec_start = 1'b1;
        wr(0, 9'd1, 1);
        dec_start = 1'b0;
        chk("decode_still_ready", 32'(bit_ready), 1);
        send_code(9'd0, 1, 0, 1'b0);
        drain("ignored_wr_drained");

        // Clear mid-code: partial 1,1 discarded, table emptied
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b1, 1'b0, 0);
        clr();
        chk("clr_bit_ready", 32'(bit_ready), 0);
        chk("clr_sym_valid", 32'(sym_valid), 0);
        start();
        send_bit(1'b0, 1'b0, 0);
        drain("cleared_table_drained");
        clr();
        load_basic();
        start();
        send_code(9'd0, 1, 0, 1'b0);
        drain("reload_drained");

        // Duplicate codes: lowest index wins; later write overwrites earlier
        clr();
        wr(7, 9'd1, 1);
        wr(5, 9'd1, 1);
        wr(9, 9'd1, 2);
        wr(9, 9'd0, 1);
        start();
        send_code(9'd1, 1, 5, 1'b0);
        send_code(9'd0, 1, 9, 1'b0);
        drain("dup_drained");

        // Overlong code: nine 1s against a table holding only 0/len 1
        clr();
        wr(0, 9'd0, 1);
        start();
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b0, 0);
`ifdef HUFF_DEC_ERR_EN
        chk("ovl_err", 32'(err), 1);
        chk("ovl_bit_ready", 32'(bit_ready), 0);
        send_bit(1'b0, 1'b0, 0);
        chk("ovl_err_held", 32'(err), 1);
        clr();
        chk("ovl_clr_err", 32'(err), 0);
        chk("ovl_clr_bit_ready", 32'(bit_ready), 0);
        start();
        send_bit(1'b0, 1'b0, 0);
        drain("ovl_lens_cleared");
`else
        chk("ovl_err", 32'(err), 0);
        chk("ovl_bit_ready", 32'(bit_ready), 1);
        send_code(9'd0, 1, 0, 1'b0);
        drain("ovl_drained");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
